// File: rtl/port_sdcm_fifo.sv
// PicoBlaze port bridge to the sdspihost SD-card block reader with a prefetch FIFO.
// Define PORT_SDCM_AUTOINC_EN to advance host_block_addr after each completed block.
module port_sdcm_fifo #(
  parameter int ADDR_BYTES  = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  addr,
  input  logic        w_strobe,
  input  logic        r_strobe,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        host_busy,
  input  logic        host_err,
  input  logic [7:0]  host_data,
  output logic        host_r_block,
  output logic        host_r_byte,
  output logic [31:0] host_block_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(BLOCK_BYTES + 1);
  localparam logic [RW-1:0] BLK      = RW'(BLOCK_BYTES);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [1:0]    LAST_IDX = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_FETCH, S_PUSH, S_REQ, S_SETTLE, S_ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      idx;
  logic [RW-1:0]   rem;
  logic            err, underflow, cmd_rej;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [31:0]     rem_w;
  logic [7:0]      rem_sat, head, status;

  logic cmd_wr, cmd_load, cmd_start, cmd_abort;
  logic accepted, rejected, block_done;
  logic fifo_full, fifo_empty, push, pop_req, pop;

  assign cmd_wr     = enable && w_strobe && (addr == 2'd0);
  assign cmd_load   = cmd_wr && (din == 8'h01);
  assign cmd_start  = cmd_wr && (din == 8'h02);
  assign cmd_abort  = cmd_wr && (din == 8'h08);
  assign fifo_full  = (cnt == DEPTH);
  assign fifo_empty = (cnt == {CW{1'b0}});
  assign push       = (state == S_PUSH) && !cmd_abort;
  assign pop_req    = enable && r_strobe && (addr == 2'd1);
  assign pop        = pop_req && !fifo_empty && !cmd_abort;
  assign block_done = push && (rem == RW'(1));

  // Abort always wins; LOAD is honoured from IDLE and ERROR, START only from IDLE.
  assign accepted = cmd_abort || ((state == S_IDLE) && (cmd_load || cmd_start))
                    || ((state == S_ERROR) && cmd_load);
  assign rejected = (cmd_load || cmd_start) && !accepted
                    && (state != S_IDLE) && (state != S_ADDR);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (cmd_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (cmd_load) state_nxt = S_ADDR;
                  else if (cmd_start) state_nxt = S_FETCH;
                  else state_nxt = S_IDLE;
        S_ADDR:   if (cmd_wr && (idx == LAST_IDX)) state_nxt = S_IDLE;
                  else state_nxt = S_ADDR;
        S_FETCH:  if (host_err) state_nxt = S_ERROR;
                  else if (!host_busy && !fifo_full) state_nxt = S_PUSH;
                  else state_nxt = S_FETCH;
        S_PUSH:   if (block_done) state_nxt = S_IDLE;
                  else state_nxt = S_REQ;
        S_REQ:    state_nxt = S_SETTLE;
        S_SETTLE: state_nxt = S_FETCH;
        S_ERROR:  if (cmd_load) state_nxt = S_ADDR;
                  else state_nxt = S_ERROR;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Host handshake outputs, decoded from state so reset drops them at once
  always_comb begin
    host_r_block = 1'b0;
    host_r_byte  = 1'b0;
    case (state)
      S_FETCH, S_PUSH, S_SETTLE: host_r_block = 1'b1;
      S_REQ:   begin host_r_block = 1'b1; host_r_byte = 1'b1; end
      default: host_r_block = 1'b0;
    endcase
  end

  // Address byte index, block address and remaining-byte counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx             <= 2'd0;
      rem             <= {RW{1'b0}};
      host_block_addr <= 32'h0000_0000;
    end else begin
      if (accepted && cmd_load) idx <= 2'd0;
      else if ((state == S_ADDR) && cmd_wr && !cmd_abort) idx <= idx + 2'd1;
      else idx <= idx;

      if (cmd_abort) rem <= {RW{1'b0}};
      else if (accepted && cmd_start) rem <= BLK;
      else if (push) rem <= rem - RW'(1);
      else rem <= rem;

      if ((state == S_ADDR) && cmd_wr && !cmd_abort)
        host_block_addr[{idx, 3'b000} +: 8] <= din;
`ifdef PORT_SDCM_AUTOINC_EN
      else if (block_done)
        host_block_addr <= (host_block_addr + 32'd1) &
                           ((ADDR_BYTES >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * ADDR_BYTES)) - 32'd1));
`endif
      else
        host_block_addr <= host_block_addr;
    end
  end

  // Sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      underflow <= 1'b0;
      cmd_rej   <= 1'b0;
    end else if (cmd_abort) begin
      err       <= 1'b0;
      underflow <= 1'b0;
      cmd_rej   <= 1'b0;
    end else begin
      err       <= err | ((state == S_FETCH) && host_err);
      underflow <= underflow | (pop_req && fifo_empty);
      if (rejected) cmd_rej <= 1'b1;
      else if (accepted) cmd_rej <= 1'b0;
      else cmd_rej <= cmd_rej;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves cnt unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      cnt    <= {CW{1'b0}};
    end else if (cmd_abort) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      cnt    <= {CW{1'b0}};
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop  ? rd_ptr + AW'(1) : rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_data;
    else      mem[wr_ptr] <= mem[wr_ptr];
  end

  // Read mux
  always_comb begin
    rem_w   = 32'(rem);
    rem_sat = (rem_w > 32'd255) ? 8'hFF : rem_w[7:0];
    head    = fifo_empty ? 8'h00 : mem[rd_ptr];
    status  = {2'b00, cmd_rej, underflow, fifo_full, err,
               (state != S_IDLE) && (state != S_ERROR), !fifo_empty};
    dout    = 8'h00;
    if (enable && r_strobe) begin
      case (addr)
        2'd0:    dout = status;
        2'd1:    dout = head;
        2'd2:    dout = 8'(cnt);
        2'd3:    dout = rem_sat;
        default: dout = 8'h00;
      endcase
    end else begin
      dout = 8'h00;
    end
  end

endmodule
